// File: rtl/dt_seq_engine.sv
// rtl/dt_seq_engine.sv - sequential decision-tree inference engine
// Streams in one feature vector, then walks a runtime-loaded node table one node per cycle.
module dt_seq_engine #(
  parameter int N     = 8,
  parameter int C     = 1,
  parameter int F     = 30,
  parameter int NODES = 32,
  localparam int FW   = $clog2(F),
  localparam int AW   = $clog2(NODES),
  localparam int W    = 1 + FW + N + 2 * AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  output logic          cfg_busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [C-1:0]  out_cls,
  output logic          out_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WALK, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_tbl  [NODES];
  logic [N-1:0]  r_feat [2**FW];
  logic [FW-1:0] r_cnt;
  logic [AW-1:0] r_node;
  logic [AW-1:0] r_steps;
  logic [C-1:0]  r_cls;
  logic          r_err;
  logic          r_out_valid;

  logic          w_beat;
  logic          w_last_beat;
  logic [W-1:0]  w_word;
  logic          w_leaf;
  logic [FW-1:0] w_fidx;
  logic [N-1:0]  w_thresh;
  logic [AW-1:0] w_left;
  logic [AW-1:0] w_right;
  logic [N-1:0]  w_fval;
  logic          w_step_max;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign cfg_busy  = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_cls   = r_cls;
  assign out_err   = r_err;

  assign w_beat      = in_valid && in_ready;
  assign w_last_beat = (r_cnt == FW'(F - 1));
  assign w_word      = r_tbl[r_node];
  assign w_leaf      = w_word[W-1];
  assign w_fidx      = w_word[W-2 -: FW];
  assign w_thresh    = w_word[2*AW+N-1 : 2*AW];
  assign w_left      = w_word[2*AW-1 : AW];
  assign w_right     = w_word[AW-1 : 0];
  assign w_step_max  = (r_steps == AW'(NODES - 1));
  // Out-of-range feature indices compare as zero.
  assign w_fval      = ({1'b0, w_fidx} < (FW + 1)'(F)) ? r_feat[w_fidx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_beat) w_next = (F == 1) ? S_WALK : S_LOAD;
      S_LOAD: if (w_beat && w_last_beat) w_next = S_WALK;
      S_WALK: if (w_leaf || w_step_max) w_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) r_tbl[i] <= '0;
      for (int i = 0; i < 2**FW; i++) r_feat[i] <= '0;
      r_cnt       <= '0;
      r_node      <= '0;
      r_steps     <= '0;
      r_cls       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (cfg_we && (r_state == S_IDLE)) r_tbl[cfg_addr] <= cfg_data;
      // out_valid trails DONE entry by one edge and drops on the handshake edge.
      r_out_valid <= (r_state == S_DONE) && !(r_out_valid && out_ready);
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_feat[0] <= in_data;
            r_cnt     <= FW'(1);
            r_node    <= '0;
            r_steps   <= '0;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_feat[r_cnt] <= in_data;
            r_cnt         <= r_cnt + FW'(1);
            if (w_last_beat) begin
              r_node  <= '0;
              r_steps <= '0;
            end
          end
        end
        S_WALK: begin
          if (w_leaf) begin
            r_cls <= w_thresh[C-1:0];
            r_err <= 1'b0;
          end else if (w_step_max) begin
            r_cls <= '0;
            r_err <= 1'b1;
          end else begin
            r_node  <= (w_fval < w_thresh) ? w_left : w_right;
            r_steps <= r_steps + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dt_seq_engine.sv
// tb/tb_dt_seq_engine.sv - self-checking bench for dt_seq_engine
// Directed vectors over a 3-node tree plus reset, backpressure and busy-write sequences.
module tb_dt_seq_engine;

  localparam int N = 8, C = 1, F = 30, NODES = 32;
  localparam int FW = 5, AW = 5, W = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [C-1:0]  out_cls;
  logic          out_err;

  dt_seq_engine #(.N(N), .C(C), .F(F), .NODES(NODES)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cls(out_cls), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int t_last = 0;

  typedef struct {
    logic [7:0] f22;
    logic       cls;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  localparam logic [W-1:0] NODE0   = {1'b0, 5'd22, 8'd49, 5'd1, 5'd2};
  localparam logic [W-1:0] NODE1   = {1'b1, 5'd0, 8'd0, 10'd0};
  localparam logic [W-1:0] NODE2   = {1'b1, 5'd0, 8'd1, 10'd0};
  localparam logic [W-1:0] NODE1_X = {1'b1, 5'd0, 8'd1, 10'd0};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic beat(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("beat_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] f22, input bit gaps);
    for (int k = 0; k < F; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) tick();
      end
      beat((k == 22) ? f22 : 8'($urandom_range(0, 255)));
    end
    t_last = cyc;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic get_result(input string name, input logic cls, input logic err, input int lat);
    wait_out(name);
    chk({name, "_lat"}, cyc - t_last, lat);
    chk({name, "_cls"}, int'(out_cls), int'(cls));
    chk({name, "_err"}, int'(out_err), int'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{8'd48,  1'b0, 1'b0, 3};
    vecs[1] = '{8'd49,  1'b1, 1'b0, 3};
    vecs[2] = '{8'd255, 1'b1, 1'b0, 3};
    vecs[3] = '{8'd0,   1'b0, 1'b0, 3};
    vecs[4] = '{8'd50,  1'b1, 1'b0, 3};
    vecs[5] = '{8'd1,   1'b0, 1'b0, 3};

    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_cls", int'(out_cls), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_cfg_busy", int'(cfg_busy), 0);

    // Cleared table: every node is a self-loop, so the walk must time out.
    send_vec(8'd7, 1'b0);
    get_result("unprog", 1'b0, 1'b1, NODES + 1);

    cfg_write(5'd0, NODE0);
    cfg_write(5'd1, NODE1);
    cfg_write(5'd2, NODE2);

    for (int i = 0; i < 6; i++) begin
      send_vec(vecs[i].f22, i[0]);
      get_result($sformatf("vec%0d", i), vecs[i].cls, vecs[i].err, vecs[i].lat);
    end

    // Backpressure: hold out_ready low while the next vector waits at the input.
    send_vec(8'd200, 1'b1);
    wait_out("bp");
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("bp_valid%0d", j), int'(out_valid), 1);
      chk($sformatf("bp_cls%0d", j), int'(out_cls), 1);
      chk($sformatf("bp_in_ready%0d", j), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_idle_in_ready", int'(in_ready), 1);
    chk("bp_idle_valid", int'(out_valid), 0);
    send_vec(8'd10, 1'b1);
    get_result("bp_second", 1'b0, 1'b0, 3);

    // A write while walking must be dropped.
    send_vec(8'd48, 1'b0);
    chk("walk_cfg_busy", int'(cfg_busy), 1);
    cfg_write(5'd1, NODE1_X);
    get_result("busy_wr", 1'b0, 1'b0, 3);
    send_vec(8'd48, 1'b0);
    get_result("busy_rb", 1'b0, 1'b0, 3);

    // Reset in the middle of a walk clears the table.
    send_vec(8'd100, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstw_out_valid", int'(out_valid), 0);
    chk("rstw_in_ready", int'(in_ready), 1);
    chk("rstw_cfg_busy", int'(cfg_busy), 0);
    #3 rst_n = 1'b1;
    tick();
    send_vec(8'd100, 1'b0);
    get_result("rstw_next", 1'b0, 1'b1, NODES + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
